// File: rtl/clk_sched_pkg.sv
// clk_sched_pkg: shared types and the decade half-period table for the clock scheduler.
package clk_sched_pkg;

    localparam int CTR_W = 26;

    typedef logic [2:0] rate_t;

    typedef enum logic [1:0] {
        STOPPED,
        RUN_MANUAL,
        RUN_SWEEP,
        STOPPING
    } state_t;

    // Half-period in CLK100MHZ cycles, indexed by rate (0 = 10 MHz ... 7 = 1 Hz)
    localparam logic [CTR_W-1:0] HALF_TABLE [8] = '{
        26'd5, 26'd50, 26'd500, 26'd5_000,
        26'd50_000, 26'd500_000, 26'd5_000_000, 26'd50_000_000
    };

    // Sweep steps toward faster rates; 3-bit arithmetic wraps 0 -> 7
    function automatic rate_t next_sweep_rate(input rate_t r);
        return r - 3'd1;
    endfunction

endpackage

// File: rtl/clk_half_period_ctr.sv
// clk_half_period_ctr: free-running half-period counter with a loadable limit and a wrap strobe.
module clk_half_period_ctr
    import clk_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_run,
    input  logic [CTR_W-1:0] i_limit,
    output logic             o_wrap
);

    logic [CTR_W-1:0] r_cnt;

    assign o_wrap = i_run && (r_cnt == i_limit - CTR_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n || !i_run)
            r_cnt <= '0;
        else
            r_cnt <= o_wrap ? '0 : r_cnt + CTR_W'(1);
    end

endmodule

// File: rtl/clk_decade_scheduler.sv
// clk_decade_scheduler: glitch-free 50% clock at a decade rate (10 MHz .. 1 Hz) from 100 MHz,
// with manual select, auto sweep and stop/start applied only at output-period boundaries.
module clk_decade_scheduler
    import clk_sched_pkg::*;
#(
    parameter int    HOLD_PERIODS = 10,
    parameter rate_t SEL_RESET    = 3'd7
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic       en,
    input  logic       sweep,
    input  logic [2:0] sel,
    output logic       clk_out,
    output logic       tick,
    output logic [2:0] cur_sel,
    output logic       running
);

    localparam int HW = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;

    state_t           r_state;
    state_t           w_next;
    logic             r_clk;
    logic             r_tick;
    rate_t            r_sel;
    logic [HW-1:0]    r_hold;
    logic             w_wrap;
    logic             w_bound;
    logic             w_hold_end;
    logic [CTR_W-1:0] w_limit;

    assign w_limit    = HALF_TABLE[r_sel];
    assign w_bound    = w_wrap && r_clk;
    assign w_hold_end = (r_hold == HW'(HOLD_PERIODS - 1));

    clk_half_period_ctr u_half (
        .clk     (CLK100MHZ),
        .rst_n   (CPU_RESETN),
        .i_run   (running),
        .i_limit (w_limit),
        .o_wrap  (w_wrap)
    );

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN)
            r_state <= STOPPED;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            STOPPED:    if (en) w_next = sweep ? RUN_SWEEP : RUN_MANUAL;
            RUN_MANUAL,
            RUN_SWEEP:  if (w_bound) w_next = !en ? STOPPED : (sweep ? RUN_SWEEP : RUN_MANUAL);
                        else if (!en) w_next = STOPPING;
            STOPPING:   if (en) w_next = sweep ? RUN_SWEEP : RUN_MANUAL;
                        else if (w_bound) w_next = STOPPED;
            default:    w_next = STOPPED;
        endcase
    end

    always_comb begin
        running = (r_state != STOPPED);
    end

    // Rate and hold bookkeeping move only at a boundary; a pending stop freezes cur_sel
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
            r_sel  <= SEL_RESET;
            r_hold <= '0;
        end else begin
            r_tick <= w_wrap && !r_clk;
            r_clk  <= running && (r_clk ^ w_wrap);
            if (r_state == STOPPED) begin
                r_hold <= '0;
                if (!sweep) r_sel <= sel;
            end else if (w_bound && en && r_state != STOPPING) begin
                if (r_state == RUN_SWEEP && w_hold_end) begin
                    r_sel  <= next_sweep_rate(r_sel);
                    r_hold <= '0;
                end else if (r_state == RUN_MANUAL || !sweep) begin
                    r_sel  <= sel;
                    r_hold <= '0;
                end else begin
                    r_hold <= r_hold + 1'b1;
                end
            end
        end
    end

    assign clk_out = r_clk;
    assign tick    = r_tick;
    assign cur_sel = r_sel;

endmodule

// File: tb/tb_clk_decade_scheduler.sv
// tb_clk_decade_scheduler: table-driven and scoreboard checks of period, duty, rate changes,
// sweep, stop/resume and reset of clk_decade_scheduler.
module tb_clk_decade_scheduler;

    typedef struct {
        int sel;
        int period;
        int high;
    } exp_t;

    logic       CLK100MHZ = 1'b0;
    logic       CPU_RESETN = 1'b0;
    logic       en = 1'b0;
    logic       sweep = 1'b0;
    logic [2:0] sel = 3'd0;
    logic       clk_out;
    logic       tick;
    logic [2:0] cur_sel;
    logic       running;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];

    clk_decade_scheduler #(.HOLD_PERIODS(2), .SEL_RESET(3'd7)) dut (
        .CLK100MHZ  (CLK100MHZ),
        .CPU_RESETN (CPU_RESETN),
        .en         (en),
        .sweep      (sweep),
        .sel        (sel),
        .clk_out    (clk_out),
        .tick       (tick),
        .cur_sel    (cur_sel),
        .running    (running)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;
    always @(posedge CLK100MHZ) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK100MHZ);
    endtask

    // Waits for a 1->0 output edge; reports its cycle and the high/tick samples seen before it
    task automatic wait_fall(input string name, input int lim, output int t, output int hi, output int tk);
        logic p;
        bit   ok;
        p = clk_out; ok = 0; hi = 0; tk = 0; t = cyc;
        for (int i = 0; i < lim; i++) begin
            @(negedge CLK100MHZ);
            if (p && !clk_out) begin
                t = cyc; ok = 1;
                break;
            end
            hi += int'(clk_out);
            tk += int'(tick);
            p = clk_out;
        end
        if (!ok) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_tick(input string name, input int lim);
        bit ok;
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge CLK100MHZ);
            if (tick) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        exp_t tv[3];
        exp_t e;
        int t0, t1, hi, tk;
        tv[0] = '{sel: 2, period: 1000, high: 500};
        tv[1] = '{sel: 1, period: 100,  high: 50};
        tv[2] = '{sel: 0, period: 10,   high: 5};

        // Reset state
        step(3);
        chk("rst_clk_out", int'(clk_out), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_cur_sel", int'(cur_sel), 7);
        chk("rst_running", int'(running), 0);
        CPU_RESETN = 1'b1;
        step(1);
        chk("stopped_load_sel", int'(cur_sel), 0);
        chk("stopped_running", int'(running), 0);
        en = 1'b1;
        step(1);
        chk("start_running", int'(running), 1);

        // Manual rates from the table; each new sel lands on the next boundary
        for (int i = 0; i < 3; i++) begin
            sel = 3'(tv[i].sel);
            sb.push_back(tv[i]);
            wait_fall("tbl_apply", 3000, t0, hi, tk);
            chk("tbl_cur_sel", int'(cur_sel), tv[i].sel);
            wait_fall("tbl_meas", 3000, t1, hi, tk);
            e = sb.pop_front();
            chk("tbl_period", t1 - t0, e.period);
            chk("tbl_high", hi, e.high);
            chk("tbl_ticks", tk, 1);
            chk("tbl_running", int'(running), 1);
        end

        // sel change in mid high half: period in progress completes unchanged
        wait_tick("chg_tick", 100);
        step(2);
        sel = 3'd2;
        sb.push_back('{sel: 2, period: 1000, high: 500});
        wait_fall("chg_fall", 100, t0, hi, tk);
        chk("chg_old_high", hi + 3, 5);
        chk("chg_cur_sel", int'(cur_sel), 2);
        wait_fall("chg_meas", 3000, t1, hi, tk);
        e = sb.pop_front();
        chk("chg_period", t1 - t0, e.period);
        chk("chg_high", hi, e.high);
        sel = 3'd0;
        wait_fall("chg_back", 3000, t0, hi, tk);
        chk("chg_back_sel", int'(cur_sel), 0);

        // 2-cycle en glitch inside a period: no stop, period intact
        step(3);
        en = 1'b0;
        step(2);
        en = 1'b1;
        wait_fall("glitch", 100, t1, hi, tk);
        chk("glitch_period", t1 - t0, 10);
        chk("glitch_running", int'(running), 1);
        wait_fall("glitch2", 100, t0, hi, tk);
        chk("glitch_next_period", t0 - t1, 10);

        // 1-cycle reset in mid high half
        wait_tick("rst_tick_wait", 100);
        step(2);
        CPU_RESETN = 1'b0;
        step(1);
        CPU_RESETN = 1'b1;
        chk("mid_rst_clk_out", int'(clk_out), 0);
        chk("mid_rst_cur_sel", int'(cur_sel), 7);
        chk("mid_rst_running", int'(running), 0);
        chk("mid_rst_tick", int'(tick), 0);

        // Stop requested in the high half: finish the half, fall, stay quiet
        wait_tick("stop_tick_wait", 100);
        step(2);
        en = 1'b0;
        wait_fall("stop_fall", 100, t0, hi, tk);
        chk("stop_high", hi + 3, 5);
        chk("stop_running", int'(running), 0);
        hi = 0;
        tk = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK100MHZ);
            hi += int'(clk_out);
            tk += int'(tick);
        end
        chk("stopped_high", hi, 0);
        chk("stopped_ticks", tk, 0);
        chk("stopped_running2", int'(running), 0);

        // Sweep from rate 1 with 2 periods held per rate, wrapping 0 -> 7
        sel = 3'd1;
        step(1);
        chk("sweep_start_sel", int'(cur_sel), 1);
        sweep = 1'b1;
        en = 1'b1;
        sb.push_back('{sel: 0, period: 100, high: 50});
        sb.push_back('{sel: 0, period: 10,  high: 5});
        sb.push_back('{sel: 7, period: 10,  high: 5});
        wait_fall("sweep_p1", 300, t0, hi, tk);
        chk("sweep_p1_sel", int'(cur_sel), 1);
        while (sb.size() > 0) begin
            wait_fall("sweep_p", 300, t1, hi, tk);
            e = sb.pop_front();
            chk("sweep_period", t1 - t0, e.period);
            chk("sweep_high", hi, e.high);
            chk("sweep_cur_sel", int'(cur_sel), e.sel);
            t0 = t1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
